shift_seq_ctrl: RTL

Sequencer for the team's 4-bit shift register datapath.
- Accepts a parallel word on a Start request and loads it.
- Clocks exactly WIDTH serial shifts, sending out MSB-first while capturing a serial input. This is full-duplex, SPI-style.
- Presents the captured word with a one-cycle Done pulse.
- Sits between a parallel host and a serial peripheral, with Shift_en framing each bit.

---
 rtl/shift_pkg.sv | 11 +
 rtl/shift_seq_dp.sv | 31 +++
 rtl/shift_seq_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_seq_dp.sv
// Shift register datapath: parallel load, MSB-first serial out, LSB serial in.
module shift_seq_dp #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_sin,
  output logic             o_msb,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_q;

  // o_next is the value the register takes on a shift edge.
  assign o_next = {r_q[WIDTH-2:0], i_sin};
  assign o_msb  = r_q[WIDTH-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift) begin
      r_q <= o_next;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Full-duplex shift sequencer: loads a word, clocks WIDTH shifts, presents
// the captured word with a one-cycle done pulse.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_din_par,
  input  logic             i_sin,
  output logic             o_sout,
  output logic             o_shift_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_dout_par,
  output logic [CNT_W-1:0] o_bit_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_dout;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_msb;
  logic [WIDTH-1:0] w_next;

  assign w_last = (r_bit_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = i_abort ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_shift = 1'b1;
          if (w_last) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_dout    <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_hold <= i_din_par;
        end
        ST_LOAD: begin
          r_bit_cnt <= '0;
        end
        ST_SHIFT: begin
          if (i_abort) begin
            r_bit_cnt <= '0;
          end else begin
            // Final edge leaves the count at WIDTH for the DONE cycle.
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (w_last) r_dout <= w_next;
          end
        end
        ST_DONE: begin
          r_bit_cnt <= '0;
        end
        default: begin
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  shift_seq_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_shift(w_shift),
    .i_din  (r_hold),
    .i_sin  (i_sin),
    .o_msb  (w_msb),
    .o_next (w_next)
  );

  assign o_shift_en = (r_state == ST_SHIFT);
  assign o_sout     = o_shift_en & w_msb;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_dout_par = r_dout;
  assign o_bit_cnt  = r_bit_cnt;

endmodule
